e203_tb_cmt_monitor: RTL and testbench
======================================

Name: e203_tb_cmt_monitor

Overview:
Synthesizable end-of-test monitor for the E203 simulation top. It consumes the EXU commit stream (commit valid/PC), the EXU dispatch handshake, register x3 and the bench IRQ-busy flag, and produces the cycle, instruction and tohost counters plus a terminal verdict. The bench top instantiates it and only prints results and calls $finish. It replaces the bench's ad-hoc counters, its unused PC-stall registers and its watchdog with one cycle-accurate block that can be verified on its own.

Parameters:
PC_SIZE, 32, commit PC width
XLEN, 32, width of x3
TOHOST_PC, 32'h80000042, PC of the tohost store instruction
TOHOST_HITS, 8, tohost commits required to end the test
STALL_LIMIT, 100, consecutive cycles without PC progress before STALL (1..127)
TIMEOUT_BIT, 20, cycle_cnt bit that triggers TIMEOUT when it becomes 1

Ports:
clk  in  1  core clock (hfclk)
rst_n  in  1  synchronous active-low reset
cmt_valid  in  1  ALU commit valid
cmt_pc  in  PC_SIZE  ALU commit PC
disp_valid  in  1  EXU i_valid
disp_ready  in  1  EXU i_ready
x3_val  in  XLEN  current value of regfile x3
irq_busy  in  1  any bench-forced IRQ (ext/sft/tmr) still asserted
cycle_cnt  out  32  cycles since reset; frozen in terminal states
instr_cnt  out  32  dispatched instructions before the first tohost hit
end_cycle  out  32  cycle_cnt value latched at the first tohost hit
tohost_cnt  out  32  number of commits at TOHOST_PC
state  out  3  RUN=0, DRAIN=1, DONE=2, TIMEOUT=3, STALL=4
done  out  1  state is DONE, TIMEOUT or STALL
pass  out  1  DONE and latched x3 == 1

Behaviour:
- Reset is synchronous: on a clk edge with rst_n=0, all counters, end_cycle, the first-hit flag, prev_pc, stall_cnt and the x3 latch clear to 0, and state goes to RUN. An assertion of rst_n in any state, including a terminal state, returns the block to RUN with all values at 0.
- cycle_cnt: increments by 1 every cycle in RUN and DRAIN and holds in the terminal states. It wraps modulo 2^32, but TIMEOUT is always reached first.
- instr_cnt: increments when disp_valid & disp_ready & ~first_hit, in RUN or DRAIN.
- tohost_cnt: increments on cmt_valid & (cmt_pc == TOHOST_PC) in RUN or DRAIN, saturating at 32'hFFFFFFFF.
- First hit: on the first such commit, first_hit is set and end_cycle latches the pre-increment cycle_cnt. end_cycle never updates again until reset.
- Stall detector (active in RUN only): prev_pc resets to 0.
  - On cmt_valid with cmt_pc != prev_pc: prev_pc <= cmt_pc and stall_cnt <= 0.
  - Otherwise stall_cnt increments, saturating at 7'h7F.
  - stall_cnt is held at 0 in DRAIN.
- FSM transitions out of RUN, evaluated per cycle in priority order:
  1. cycle_cnt[TIMEOUT_BIT]==1 -> TIMEOUT.
  2. Else stall_cnt == STALL_LIMIT-1 with no progress this cycle -> STALL.
  3. Else a tohost hit that makes tohost_cnt reach TOHOST_HITS (next value == TOHOST_HITS) -> DRAIN.
- DRAIN: if the timeout condition holds -> TIMEOUT. Else if irq_busy==0 -> DONE, and x3_val[XLEN-1:0]==1 is latched into the x3 latch on that edge. Otherwise stay in DRAIN. DRAIN lasts at least 1 cycle.
- DONE, TIMEOUT and STALL are terminal; only reset leaves them.
- pass is registered: it is 1 only in DONE with the latched x3 check true. Later changes to x3_val do not affect pass.
- All outputs are registered; state and done change on the same edge.
- Latency: DRAIN->DONE is 1 cycle after irq_busy is seen low. done is visible the cycle after that edge.

Test Plan:
1. Reset, then 8 commits at 0x80000042 spaced 10 cycles apart, with PC progress between them, irq_busy=0 and x3=1 -> state DRAIN after the 8th hit, DONE one cycle later, pass=1, tohost_cnt=8.
2. Same as scenario 1 with x3=5 at the DRAIN exit, then x3=1 afterwards -> DONE with pass=0, and pass stays 0.
3. First tohost hit at cycle_cnt=37 with 20 dispatch handshakes beforehand and 5 afterwards -> end_cycle=37, instr_cnt=20.
4. Hold irq_busy=1 through the 8th hit for 15 cycles, then drop it -> DRAIN for 16 cycles, then DONE. cycle_cnt keeps counting in DRAIN and freezes in DONE.
5. No commits after reset with STALL_LIMIT=100 -> STALL exactly 100 cycles after reset, done=1, pass=0, cycle_cnt frozen at 100.
6. With TIMEOUT_BIT=6, commits at ever-changing PCs and no tohost hit -> TIMEOUT when cycle_cnt=64. Assert rst_n=0 for 1 cycle -> state RUN with all counters at 0.

Source files
------------

// File: rtl/e203_tb_cmt_monitor.sv
// ---------------------------------------------------------------------------
// e203_tb_cmt_monitor
//
// End-of-test monitor for the E203 simulation top. It watches the EXU commit
// stream, the EXU dispatch handshake, regfile x3 and the bench IRQ-busy flag.
// It keeps the cycle, instruction and tohost counters and reaches one of three
// terminal verdicts: DONE (tohost reached and IRQs drained), TIMEOUT (the cycle
// counter hit its limit bit) or STALL (the commit PC stopped making progress).
//
// Ports
//   clk, rst_n          core clock, synchronous active-low reset
//   cmt_valid, cmt_pc   ALU commit valid / PC
//   disp_valid/ready    EXU dispatch handshake (i_valid / i_ready)
//   x3_val              current regfile x3 (test result register)
//   irq_busy            a bench-forced IRQ is still asserted
//   cycle_cnt           cycles since reset, frozen in terminal states
//   instr_cnt           dispatched instructions before the first tohost hit
//   end_cycle           cycle_cnt captured at the first tohost hit
//   tohost_cnt          commits seen at TOHOST_PC (saturating)
//   state               RUN=0 DRAIN=1 DONE=2 TIMEOUT=3 STALL=4
//   done                state is terminal
//   pass                DONE and x3 was 1 on the DRAIN exit edge
// ---------------------------------------------------------------------------
module e203_tb_cmt_monitor #(
  parameter int unsigned         PC_SIZE     = 32,
  parameter int unsigned         XLEN        = 32,
  parameter logic [PC_SIZE-1:0]  TOHOST_PC   = PC_SIZE'(32'h8000_0042),
  parameter int unsigned         TOHOST_HITS = 8,
  parameter int unsigned         STALL_LIMIT = 100,
  parameter int unsigned         TIMEOUT_BIT = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmt_valid,
  input  logic [PC_SIZE-1:0] cmt_pc,
  input  logic               disp_valid,
  input  logic               disp_ready,
  input  logic [XLEN-1:0]    x3_val,
  input  logic               irq_busy,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        instr_cnt,
  output logic [31:0]        end_cycle,
  output logic [31:0]        tohost_cnt,
  output logic [2:0]         state,
  output logic               done,
  output logic               pass
);

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_DONE    = 3'd2,
    ST_TIMEOUT = 3'd3,
    ST_STALL   = 3'd4
  } state_e;

  state_e             state_q,     state_d;
  logic [31:0]        cycle_q,     cycle_d;
  logic [31:0]        instr_q,     instr_d;
  logic [31:0]        end_q,       end_d;
  logic [31:0]        tohost_q,    tohost_d;
  logic               first_hit_q, first_hit_d;
  logic [PC_SIZE-1:0] prev_pc_q,   prev_pc_d;
  logic [6:0]         stall_q,     stall_d;
  logic               x3_ok_q,     x3_ok_d;
  logic               done_q,      done_d;
  logic               pass_q,      pass_d;

  logic active;
  logic hit;
  logic progress;
  logic timeout_hit;
  logic stall_hit;

  always_comb begin
    state_d     = state_q;
    cycle_d     = cycle_q;
    instr_d     = instr_q;
    end_d       = end_q;
    tohost_d    = tohost_q;
    first_hit_d = first_hit_q;
    prev_pc_d   = prev_pc_q;
    stall_d     = stall_q;
    x3_ok_d     = x3_ok_q;

    active   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    hit      = cmt_valid && (cmt_pc == TOHOST_PC);
    progress = cmt_valid && (cmt_pc != prev_pc_q);

    if (active) begin
      cycle_d = cycle_q + 32'd1;
      if (disp_valid && disp_ready && !first_hit_q) begin
        instr_d = instr_q + 32'd1;
      end
      if (hit) begin
        if (tohost_q != '1) begin
          tohost_d = tohost_q + 32'd1;
        end
        if (!first_hit_q) begin
          first_hit_d = 1'b1;
          end_d       = cycle_q;
        end
      end
    end

    // The limit bit is taken from the incremented count so the block stops
    // on the same edge that cycle_cnt reaches 2**TIMEOUT_BIT, leaving that
    // value frozen (mirrors STALL freezing at exactly STALL_LIMIT).
    timeout_hit = cycle_d[TIMEOUT_BIT];
    stall_hit   = (stall_q == 7'(STALL_LIMIT - 1)) && !progress;

    case (state_q)
      ST_RUN: begin
        if (progress) begin
          prev_pc_d = cmt_pc;
          stall_d   = '0;
        end else if (stall_q != 7'h7F) begin
          stall_d = stall_q + 7'd1;
        end

        if (timeout_hit) begin
          state_d = ST_TIMEOUT;
        end else if (stall_hit) begin
          state_d = ST_STALL;
        end else if (hit && (tohost_d == 32'(TOHOST_HITS))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        stall_d = '0;
        if (timeout_hit) begin
          state_d = ST_TIMEOUT;
        end else if (!irq_busy) begin
          state_d = ST_DONE;
          x3_ok_d = (x3_val == XLEN'(1));
        end
      end
      default: begin
        // terminal states hold everything until reset
      end
    endcase

    done_d = (state_d == ST_DONE) || (state_d == ST_TIMEOUT) || (state_d == ST_STALL);
    pass_d = (state_d == ST_DONE) && x3_ok_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      cycle_q     <= '0;
      instr_q     <= '0;
      end_q       <= '0;
      tohost_q    <= '0;
      first_hit_q <= 1'b0;
      prev_pc_q   <= '0;
      stall_q     <= '0;
      x3_ok_q     <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycle_q     <= cycle_d;
      instr_q     <= instr_d;
      end_q       <= end_d;
      tohost_q    <= tohost_d;
      first_hit_q <= first_hit_d;
      prev_pc_q   <= prev_pc_d;
      stall_q     <= stall_d;
      x3_ok_q     <= x3_ok_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign cycle_cnt  = cycle_q;
  assign instr_cnt  = instr_q;
  assign end_cycle  = end_q;
  assign tohost_cnt = tohost_q;
  assign state      = state_q;
  assign done       = done_q;
  assign pass       = pass_q;

endmodule

// File: tb/tb_e203_tb_cmt_monitor.sv
// ---------------------------------------------------------------------------
// tb_e203_tb_cmt_monitor
//
// Two monitors share one stimulus stream: dut_a with default parameters and
// dut_b with TIMEOUT_BIT=6 for the timeout scenario. Expected values are
// queued as stimulus is driven and compared when the outputs are sampled.
// ---------------------------------------------------------------------------
module tb_e203_tb_cmt_monitor;

  localparam logic [31:0] TOHOST = 32'h8000_0042;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmt_valid;
  logic [31:0] cmt_pc;
  logic        disp_valid;
  logic        disp_ready;
  logic [31:0] x3_val;
  logic        irq_busy;

  logic [31:0] a_cycle, a_instr, a_end, a_toh;
  logic [2:0]  a_state;
  logic        a_done, a_pass;
  logic [31:0] b_cycle, b_instr, b_end, b_toh;
  logic [2:0]  b_state;
  logic        b_done, b_pass;

  always #5 clk = ~clk;

  e203_tb_cmt_monitor #(
    .PC_SIZE    (32),
    .XLEN       (32),
    .TOHOST_PC  (TOHOST),
    .TOHOST_HITS(8),
    .STALL_LIMIT(100),
    .TIMEOUT_BIT(20)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .cmt_valid(cmt_valid), .cmt_pc(cmt_pc),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .x3_val(x3_val),
    .irq_busy(irq_busy), .cycle_cnt(a_cycle), .instr_cnt(a_instr),
    .end_cycle(a_end), .tohost_cnt(a_toh), .state(a_state),
    .done(a_done), .pass(a_pass)
  );

  e203_tb_cmt_monitor #(
    .TIMEOUT_BIT(6)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .cmt_valid(cmt_valid), .cmt_pc(cmt_pc),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .x3_val(x3_val),
    .irq_busy(irq_busy), .cycle_cnt(b_cycle), .instr_cnt(b_instr),
    .end_cycle(b_end), .tohost_cnt(b_toh), .state(b_state),
    .done(b_done), .pass(b_pass)
  );

  typedef enum int {F_STATE, F_DONE, F_PASS, F_CYC, F_INSTR, F_END, F_TOH} fld_e;
  typedef struct {
    string       tag;
    bit          inst;
    fld_e        fld;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input bit inst, input fld_e f);
    case (f)
      F_STATE: return inst ? 32'(b_state) : 32'(a_state);
      F_DONE:  return inst ? 32'(b_done)  : 32'(a_done);
      F_PASS:  return inst ? 32'(b_pass)  : 32'(a_pass);
      F_CYC:   return inst ? b_cycle      : a_cycle;
      F_INSTR: return inst ? b_instr      : a_instr;
      F_END:   return inst ? b_end        : a_end;
      default: return inst ? b_toh        : a_toh;
    endcase
  endfunction

  task automatic expect_out(input string tag, input bit inst, input fld_e f, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.inst = inst;
    e.fld  = f;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, observe(e.inst, e.fld), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    cmt_valid  = 1'b0;
    cmt_pc     = '0;
    disp_valid = 1'b0;
    disp_ready = 1'b0;
    irq_busy   = 1'b0;
    x3_val     = '0;
    tick();
    rst_n = 1'b1;
  endtask

  // n tohost hits, each preceded by gap commits at fresh PCs
  task automatic run_hits(input int unsigned gap, input int unsigned n, input logic [31:0] base);
    for (int unsigned h = 0; h < n; h++) begin
      for (int unsigned g = 0; g < gap; g++) begin
        cmt_valid = 1'b1;
        cmt_pc    = base + 32'(h * 16 + g);
        tick();
      end
      cmt_valid = 1'b1;
      cmt_pc    = TOHOST;
      tick();
    end
    cmt_valid = 1'b0;
  endtask

  initial begin
    // reset state
    do_reset();
    expect_out("rst.state", 0, F_STATE, 0);
    expect_out("rst.cyc",   0, F_CYC,   0);
    expect_out("rst.done",  0, F_DONE,  0);
    sb_check();

    // 1: eight hits 10 cycles apart, irq idle, x3=1
    x3_val = 1;
    run_hits(9, 7, 32'h1000);
    expect_out("s1.hit7.state", 0, F_STATE, 0);
    expect_out("s1.hit7.toh",   0, F_TOH,   7);
    sb_check();
    expect_out("s1.drain.state", 0, F_STATE, 1);
    expect_out("s1.drain.done",  0, F_DONE,  0);
    expect_out("s1.drain.toh",   0, F_TOH,   8);
    expect_out("s1.drain.cyc",   0, F_CYC,   80);
    expect_out("s1.end",         0, F_END,   9);
    run_hits(9, 1, 32'h2000);
    sb_check();
    expect_out("s1.done.state", 0, F_STATE, 2);
    expect_out("s1.done.done",  0, F_DONE,  1);
    expect_out("s1.done.pass",  0, F_PASS,  1);
    expect_out("s1.done.cyc",   0, F_CYC,   81);
    expect_out("s1.done.toh",   0, F_TOH,   8);
    tick();
    sb_check();

    // 2: x3=5 at DRAIN exit, then x3=1 must not change pass
    do_reset();
    x3_val = 5;
    expect_out("s2.drain.state", 0, F_STATE, 1);
    run_hits(9, 8, 32'h3000);
    sb_check();
    expect_out("s2.done.state", 0, F_STATE, 2);
    expect_out("s2.done.pass",  0, F_PASS,  0);
    tick();
    sb_check();
    x3_val = 1;
    expect_out("s2.late.pass",  0, F_PASS,  0);
    expect_out("s2.late.state", 0, F_STATE, 2);
    tick();
    tick();
    sb_check();

    // 3: first hit at cycle 37, 20 handshakes before, 5 after
    do_reset();
    for (int unsigned i = 0; i < 37; i++) begin
      disp_valid = (i < 30);
      disp_ready = (i < 20) || (i >= 30);
      tick();
    end
    disp_valid = 1'b0;
    disp_ready = 1'b0;
    expect_out("s3.end",   0, F_END,   37);
    expect_out("s3.instr", 0, F_INSTR, 20);
    expect_out("s3.toh",   0, F_TOH,   1);
    expect_out("s3.state", 0, F_STATE, 0);
    cmt_valid = 1'b1;
    cmt_pc    = TOHOST;
    tick();
    cmt_valid = 1'b0;
    sb_check();
    expect_out("s3.after.instr", 0, F_INSTR, 20);
    expect_out("s3.after.end",   0, F_END,   37);
    disp_valid = 1'b1;
    disp_ready = 1'b1;
    for (int unsigned i = 0; i < 5; i++) tick();
    disp_valid = 1'b0;
    disp_ready = 1'b0;
    sb_check();

    // 4: irq busy for 15 cycles after the 8th hit
    do_reset();
    x3_val   = 1;
    irq_busy = 1'b1;
    expect_out("s4.drain.state", 0, F_STATE, 1);
    expect_out("s4.drain.cyc",   0, F_CYC,   24);
    run_hits(2, 8, 32'h4000);
    sb_check();
    expect_out("s4.busy.state", 0, F_STATE, 1);
    expect_out("s4.busy.done",  0, F_DONE,  0);
    expect_out("s4.busy.cyc",   0, F_CYC,   39);
    for (int unsigned i = 0; i < 15; i++) tick();
    sb_check();
    irq_busy = 1'b0;
    expect_out("s4.done.state", 0, F_STATE, 2);
    expect_out("s4.done.done",  0, F_DONE,  1);
    expect_out("s4.done.pass",  0, F_PASS,  1);
    expect_out("s4.done.cyc",   0, F_CYC,   40);
    tick();
    sb_check();
    expect_out("s4.frozen.cyc", 0, F_CYC,   40);
    for (int unsigned i = 0; i < 5; i++) tick();
    sb_check();

    // 5: no commits -> STALL at cycle 100
    do_reset();
    x3_val = 1;
    for (int unsigned i = 0; i < 99; i++) tick();
    expect_out("s5.pre.state", 0, F_STATE, 0);
    expect_out("s5.pre.done",  0, F_DONE,  0);
    sb_check();
    expect_out("s5.state", 0, F_STATE, 4);
    expect_out("s5.done",  0, F_DONE,  1);
    expect_out("s5.pass",  0, F_PASS,  0);
    expect_out("s5.cyc",   0, F_CYC,   100);
    tick();
    sb_check();
    expect_out("s5.frozen.cyc", 0, F_CYC, 100);
    for (int unsigned i = 0; i < 5; i++) tick();
    sb_check();

    // 6: TIMEOUT_BIT=6 instance, always-changing PCs, then reset
    do_reset();
    disp_valid = 1'b1;
    disp_ready = 1'b1;
    for (int unsigned i = 0; i < 63; i++) begin
      cmt_valid = 1'b1;
      cmt_pc    = 32'(i + 1);
      tick();
    end
    expect_out("s6.pre.state", 1, F_STATE, 0);
    expect_out("s6.pre.cyc",   1, F_CYC,   63);
    sb_check();
    expect_out("s6.state", 1, F_STATE, 3);
    expect_out("s6.done",  1, F_DONE,  1);
    expect_out("s6.pass",  1, F_PASS,  0);
    expect_out("s6.cyc",   1, F_CYC,   64);
    expect_out("s6.instr", 1, F_INSTR, 64);
    cmt_pc = 32'd64;
    tick();
    sb_check();
    expect_out("s6.frozen.cyc",   1, F_CYC,   64);
    expect_out("s6.frozen.state", 1, F_STATE, 3);
    for (int unsigned i = 0; i < 3; i++) begin
      cmt_pc = 32'(100 + i);
      tick();
    end
    sb_check();
    expect_out("s6.rst.state", 1, F_STATE, 0);
    expect_out("s6.rst.cyc",   1, F_CYC,   0);
    expect_out("s6.rst.instr", 1, F_INSTR, 0);
    expect_out("s6.rst.toh",   1, F_TOH,   0);
    expect_out("s6.rst.end",   1, F_END,   0);
    expect_out("s6.rst.done",  1, F_DONE,  0);
    expect_out("s6.rst.pass",  1, F_PASS,  0);
    rst_n = 1'b0;
    tick();
    sb_check();
    rst_n      = 1'b1;
    cmt_valid  = 1'b0;
    disp_valid = 1'b0;
    disp_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
